// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// RISC-V funct3 constants, and the lane extract/merge functions used by the
// lane aligner.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Pull the addressed byte/half/word out of a memory word and extend it.
    function automatic logic [31:0] lane_extract(
        input logic [2:0]  f3,
        input logic [1:0]  lo,
        input logic [31:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'd0;
        endcase
        if (lo[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'd0, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'd0, h};
            F3_W:    r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Overlay the low byte/half of the store data onto the addressed lane.
    function automatic logic [31:0] lane_merge(
        input logic [2:0]  f3,
        input logic [1:0]  lo,
        input logic [31:0] word,
        input logic [31:0] wdata
    );
        logic [31:0] r;
        case (f3)
            F3_B: begin
                case (lo)
                    2'd0:    r = {word[31:8], wdata[7:0]};
                    2'd1:    r = {word[31:16], wdata[7:0], word[7:0]};
                    2'd2:    r = {word[31:24], wdata[7:0], word[15:0]};
                    2'd3:    r = {wdata[7:0], word[23:0]};
                    default: r = word;
                endcase
            end
            F3_H: begin
                if (lo[1]) begin
                    r = {wdata[15:0], word[15:0]};
                end else begin
                    r = {word[31:16], wdata[15:0]};
                end
            end
            F3_W:    r = wdata;
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane aligner: extended load data and read-modify-write merge
// word, both derived from the latched funct3 and byte offset.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    // Lane extraction for loads and lane insertion for sub-word stores.
    always_comb begin
        load_data  = lane_extract(funct3, addr_lo, rdata);
        merge_data = lane_merge(funct3, addr_lo, rdata, wdata);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core memory stage and a word-addressed data
// memory. Byte/half/word accesses, read-modify-write for SB/SH, sign/zero
// extension for sub-word loads.
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned half/word
// accesses report rsp_err; otherwise the offending low address bits are
// dropped and the access proceeds.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_store,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [31:0]      rsp_rdata,
    output logic             mem_cs,
    output logic             mem_re,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    lsu_state_e       state_q, state_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             mem_re_q, mem_re_d;
    logic             mem_we_q, mem_we_d;
    logic [IDX_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;

    logic             accept_s;
    logic             oor_s;
    logic             f3_ok_s;
    logic             misalign_s;
    logic             err_s;
    logic [1:0]       eff_lo_s;
    logic [31:0]      load_data_s;
    logic [31:0]      merge_data_s;

    lsu_lane_align u_align (
        .funct3     (funct3_q),
        .addr_lo    (addr_lo_q),
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data_s),
        .merge_data (merge_data_s)
    );

    // Request decode: acceptance, error classification and effective lane offset.
    always_comb begin
        accept_s = req_valid && (state_q == ST_IDLE);
        oor_s    = (req_addr >> (IDX_W + 2)) != 32'd0;
        if (req_store) begin
            f3_ok_s = (req_funct3 == F3_B) || (req_funct3 == F3_H) ||
                      (req_funct3 == F3_W);
        end else begin
            f3_ok_s = (req_funct3 == F3_B)  || (req_funct3 == F3_H)  ||
                      (req_funct3 == F3_W)  || (req_funct3 == F3_BU) ||
                      (req_funct3 == F3_HU);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_s = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        misalign_s = 1'b0;
`endif
        err_s = oor_s || !f3_ok_s || misalign_s;
        // Halfwords keep only addr[1]; words always use lane 0.
        case (req_funct3[1:0])
            2'b01:   eff_lo_s = {req_addr[1], 1'b0};
            2'b10:   eff_lo_s = 2'b00;
            default: eff_lo_s = req_addr[1:0];
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (err_s) begin
                        state_d = ST_RESP;
                    end else if (!req_store) begin
                        state_d = ST_LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD:   state_d = ST_RESP;
            ST_RMW_RD: state_d = ST_WRITE;
            ST_WRITE:  state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; strobes are registered so they line up
    // with the state they belong to.
    always_comb begin
        addr_lo_d   = addr_lo_q;
        funct3_d    = funct3_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = (state_d == ST_RESP);
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;
        mem_re_d    = (state_d == ST_LOAD) || (state_d == ST_RMW_RD);
        mem_we_d    = (state_d == ST_WRITE);
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    addr_lo_d = eff_lo_s;
                    funct3_d  = req_funct3;
                    wdata_d   = req_wdata;
                    rsp_err_d = err_s;
                    if (!err_s) begin
                        mem_addr_d = req_addr[IDX_W+1:2];
                        if (req_store && (req_funct3 == F3_W)) begin
                            mem_wdata_d = req_wdata;
                        end else begin
                            mem_wdata_d = mem_wdata_q;
                        end
                    end else begin
                        mem_addr_d = mem_addr_q;
                    end
                end else begin
                    addr_lo_d = addr_lo_q;
                end
            end
            ST_LOAD:   rsp_rdata_d = load_data_s;
            ST_RMW_RD: mem_wdata_d = merge_data_s;
            default:   rsp_rdata_d = 32'd0;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_lo_q   <= 2'd0;
            funct3_q    <= 3'd0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
        end else begin
            addr_lo_q   <= addr_lo_d;
            funct3_q    <= funct3_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Chip select also rides on reset so the memory clears on the reset edge.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = rsp_valid_q;
        rsp_err   = rsp_err_q;
        rsp_rdata = rsp_rdata_q;
        mem_re    = mem_re_q;
        mem_we    = mem_we_q;
        mem_cs    = reset || mem_re_q || mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural data memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_cs;
    logic        mem_re;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:511];
    int          we_cnt = 0;
    int          re_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    load_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .mem_cs     (mem_cs),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    // Behavioural memory: clears under reset+cs, synchronous write, strobe counters.
    always @(posedge clk) begin
        if (mem_cs && reset) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'd0;
        end else if (mem_cs && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_we) we_cnt <= we_cnt + 1;
        if (mem_re) re_cnt <= re_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic exp_err,
                          input logic [31:0] exp_rdata, input int exp_we, input int exp_re);
        int k;
        int we0;
        int re0;
        @(negedge clk);
        check({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        we0 = we_cnt;
        re0 = re_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check({tag, "_ready_busy"}, {31'd0, req_ready}, 32'd0);
        k = 1;
        while (!rsp_valid && k < 8) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_latency"}, k, exp_lat);
        check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        @(posedge clk);
        #1;
        check({tag, "_pulse_len"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_we_cnt"}, we_cnt - we0, exp_we);
        check({tag, "_re_cnt"}, re_cnt - re0, exp_re);
    endtask

    initial begin
        int vcnt;
        int we0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("cs_in_reset", {31'd0, mem_cs}, 32'd1);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_re", {31'd0, mem_re}, 32'd0);
        check("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_cs", {31'd0, mem_cs}, 32'd0);

        do_req("sw10", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'd0, 1, 0);
        check("sw10_mem_addr", {23'd0, mem_addr}, 32'd4);
        check("sw10_mem", mem[4], 32'hDEADBEEF);
        do_req("lw10", 1'b0, F3_W, 32'h10, 32'd0, 2, 1'b0, 32'hDEADBEEF, 0, 1);
        do_req("sb11", 1'b1, F3_B, 32'h11, 32'hAAAAAA55, 3, 1'b0, 32'd0, 1, 1);
        check("sb11_mem", mem[4], 32'hDEAD55EF);
        do_req("lb13", 1'b0, F3_B, 32'h13, 32'd0, 2, 1'b0, 32'hFFFFFFDE, 0, 1);
        do_req("lbu13", 1'b0, F3_BU, 32'h13, 32'd0, 2, 1'b0, 32'h000000DE, 0, 1);
        do_req("lh10", 1'b0, F3_H, 32'h10, 32'd0, 2, 1'b0, 32'h000055EF, 0, 1);
        do_req("lhu12", 1'b0, F3_HU, 32'h12, 32'd0, 2, 1'b0, 32'h0000DEAD, 0, 1);
        do_req("sh06", 1'b1, F3_H, 32'h06, 32'hFFFF8001, 3, 1'b0, 32'd0, 1, 1);
        check("sh06_mem", mem[1], 32'h80010000);
        do_req("lh06", 1'b0, F3_H, 32'h06, 32'd0, 2, 1'b0, 32'hFFFF8001, 0, 1);
        do_req("lw802_oor", 1'b0, F3_W, 32'h802, 32'd0, 1, 1'b1, 32'd0, 0, 0);
        do_req("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'd0, 1, 1'b1, 32'd0, 0, 0);
        do_req("st_f3_100", 1'b1, 3'b100, 32'h10, 32'h12345678, 1, 1'b1, 32'd0, 0, 0);
        check("st_f3_100_mem", mem[4], 32'hDEAD55EF);
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("lw12_mis", 1'b0, F3_W, 32'h12, 32'd0, 1, 1'b1, 32'd0, 0, 0);
`else
        do_req("lw12_mis", 1'b0, F3_W, 32'h12, 32'd0, 2, 1'b0, 32'hDEAD55EF, 0, 1);
`endif

        // Reset while an SH sits in RMW_RD.
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = F3_H;
        req_addr   = 32'h20;
        req_wdata  = 32'h0000BEEF;
        we0 = we_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rmw_re", {31'd0, mem_re}, 32'd1);
        reset = 1'b1;
        #1;
        check("rmw_cs_reset", {31'd0, mem_cs}, 32'd1);
        @(posedge clk);
        #1;
        check("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
        check("rmw_rst_we", {31'd0, mem_we}, 32'd0);
        check("rmw_rst_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) vcnt++;
        end
        check("rmw_no_rsp", vcnt, 32'd0);
        check("rmw_no_we", we_cnt - we0, 32'd0);
        do_req("lw20_after", 1'b0, F3_W, 32'h20, 32'd0, 2, 1'b0, 32'd0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
